// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the ID/stage A pipeline registers and the hazard/stall controller.
// master = pipeline side (drives decode/stage A fields), slave = controller.
interface hazard_stall_ctrl_if;
  logic       id_valid;
  logic [3:0] id_rs1;
  logic [3:0] id_rs2;
  logic       id_use1;
  logic       id_use2;
  logic       id_halt;
  logic [7:0] ex_instr;
  logic [1:0] ex_memc;
  logic       ex_reg_wr;
  logic [3:0] ex_alu_ctrl;
  logic       stall_front;
  logic       stall_a;
  logic       bubble_a;
  logic       bubble_b;
  logic       haz1;
  logic       haz2;
  logic       halt_sys;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use1, id_use2, id_halt,
    output ex_instr, ex_memc, ex_reg_wr, ex_alu_ctrl,
    input  stall_front, stall_a, bubble_a, bubble_b, haz1, haz2, halt_sys
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use1, id_use2, id_halt,
    input  ex_instr, ex_memc, ex_reg_wr, ex_alu_ctrl,
    output stall_front, stall_a, bubble_a, bubble_b, haz1, haz2, halt_sys
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard, stall, multi-cycle sequencing and drain-then-halt controller for the 4-stage core.
// Optional macro HAZ_FWD_EN: forward ALU results via haz1/haz2 instead of bubbling on every RAW.
module hazard_stall_ctrl #(
  parameter int         MC_CYCLES = 4,
  parameter logic [3:0] MC_CTRL   = 4'hF
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_stall_ctrl_if.slave   io_bus,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MC_BUSY = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_mc_cnt;
  logic [3:0] w_mc_cnt_nxt;

  logic w_match1, w_match2, w_mc_op, w_load_use, w_fwd1, w_fwd2, w_eval;
  logic w_stall_front, w_stall_a, w_bubble_a, w_bubble_b, w_haz1, w_haz2, w_halt_sys;
  logic w_unused;

  assign w_unused = ^{io_bus.ex_instr[7:4], io_bus.ex_memc[0]};

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign w_match1 = io_bus.id_valid & io_bus.id_use1 & io_bus.ex_reg_wr &
                    (io_bus.ex_instr[3:0] != 4'd0) & (io_bus.id_rs1 == io_bus.ex_instr[3:0]);
  assign w_match2 = io_bus.id_valid & io_bus.id_use2 & io_bus.ex_reg_wr &
                    (io_bus.ex_instr[3:0] != 4'd0) & (io_bus.id_rs2 == io_bus.ex_instr[3:0]);
  assign w_mc_op  = (io_bus.ex_alu_ctrl == MC_CTRL);

`ifdef HAZ_FWD_EN
  assign w_load_use = (w_match1 | w_match2) & io_bus.ex_memc[1];
  assign w_fwd1     = w_match1 & ~io_bus.ex_memc[1];
  assign w_fwd2     = w_match2 & ~io_bus.ex_memc[1];
`else
  assign w_load_use = w_match1 | w_match2;
  assign w_fwd1     = 1'b0;
  assign w_fwd2     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mc_cnt <= 4'd0;
    end else begin
      r_state  <= w_next;
      r_mc_cnt <= w_mc_cnt_nxt;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_mc_cnt_nxt  = r_mc_cnt;
    w_eval        = 1'b0;
    w_stall_front = 1'b0;
    w_stall_a     = 1'b0;
    w_bubble_a    = 1'b0;
    w_bubble_b    = 1'b0;
    w_haz1        = 1'b0;
    w_haz2        = 1'b0;
    w_halt_sys    = 1'b0;

    case (r_state)
      IDLE: begin
        w_haz1 = w_fwd1;
        w_haz2 = w_fwd2;
        if (w_mc_op) begin
          w_stall_front = 1'b1;
          w_stall_a     = 1'b1;
          w_bubble_b    = 1'b1;
          w_mc_cnt_nxt  = 4'(MC_CYCLES - 2);
          w_next        = MC_BUSY;
        end else begin
          w_eval = 1'b1;
        end
      end
      MC_BUSY: begin
        if (r_mc_cnt != 4'd0) begin
          w_stall_front = 1'b1;
          w_stall_a     = 1'b1;
          w_bubble_b    = 1'b1;
          w_mc_cnt_nxt  = r_mc_cnt - 4'd1;
        end else begin
          // Release cycle: the op still sits in stage A, so do not re-detect it.
          w_next = IDLE;
          w_eval = 1'b1;
          w_haz1 = w_fwd1;
          w_haz2 = w_fwd2;
        end
      end
      DRAIN: begin
        w_stall_front = 1'b1;
        w_bubble_a    = 1'b1;
        w_next        = HALTED;
      end
      default: begin
        w_stall_front = 1'b1;
        w_halt_sys    = 1'b1;
      end
    endcase

    if (w_eval) begin
      if (w_load_use) begin
        w_stall_front = 1'b1;
        w_bubble_a    = 1'b1;
      end else if (io_bus.id_valid & io_bus.id_halt) begin
        w_stall_front = 1'b1;
        w_bubble_a    = 1'b1;
        w_next        = DRAIN;
      end
    end
  end

  // Outputs are held low while reset is asserted, whatever the inputs show.
  assign io_bus.stall_front = w_stall_front & ~rst;
  assign io_bus.stall_a     = w_stall_a & ~rst;
  assign io_bus.bubble_a    = w_bubble_a & ~rst;
  assign io_bus.bubble_b    = w_bubble_b & ~rst;
  assign io_bus.haz1        = w_haz1 & ~rst;
  assign io_bus.haz2        = w_haz2 & ~rst;
  assign io_bus.halt_sys    = w_halt_sys & ~rst;
  assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, forwarding, r0, multi-cycle, halt, reset.
// Output vector order: {stall_front, stall_a, bubble_a, bubble_b, haz1, haz2, halt_sys}.
module tb_hazard_stall_ctrl;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_errors;

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl #(.MC_CYCLES(4), .MC_CTRL(4'hF)) dut (
    .clk         (clk),
    .rst         (rst),
    .io_bus      (bus.slave),
    .o_dbg_state (dbg_state)
  );

  localparam logic [6:0] O_NONE  = 7'b000_0000;
  localparam logic [6:0] O_BUB   = 7'b101_0000;
  localparam logic [6:0] O_MC    = 7'b110_1000;
  localparam logic [6:0] O_HALT  = 7'b100_0001;
`ifdef HAZ_FWD_EN
  localparam logic [6:0] O_FWD1  = 7'b000_0100;
  localparam logic [6:0] O_FWD2  = 7'b000_0010;
`else
  localparam logic [6:0] O_FWD1  = O_BUB;
  localparam logic [6:0] O_FWD2  = O_BUB;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {bus.stall_front, bus.stall_a, bus.bubble_a, bus.bubble_b,
            bus.haz1, bus.haz2, bus.halt_sys};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [7:0] instr, input logic [1:0] memc,
                        input logic reg_wr, input logic [3:0] alu);
    bus.ex_instr    = instr;
    bus.ex_memc     = memc;
    bus.ex_reg_wr   = reg_wr;
    bus.ex_alu_ctrl = alu;
  endtask

  task automatic set_id(input logic valid, input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic use1, input logic use2, input logic halt);
    bus.id_valid = valid;
    bus.id_rs1   = rs1;
    bus.id_rs2   = rs2;
    bus.id_use1  = use1;
    bus.id_use2  = use2;
    bus.id_halt  = halt;
  endtask

  // Settle combinational outputs, then compare.
  task automatic chk(input string tag, input logic [6:0] exp_o);
    logic [6:0] obs;
    #2;
    obs = outs();
    n_checks++;
    assert (obs === exp_o) else begin
      n_errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp_o);
    end
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp_s);
    n_checks++;
    assert (dbg_state === exp_s) else begin
      n_errors++;
      $error("FAIL %s observed state %0d expected %0d", tag, dbg_state, exp_s);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    set_ex(8'h00, 2'b00, 1'b0, 4'h0);
    #1;
    // Outputs stay low in reset even with a multi-cycle op and a hazard present.
    set_ex(8'h03, 2'b10, 1'b1, 4'hF);
    set_id(1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("reset_outs", O_NONE);
    chk_state("reset_state", 2'd0);
    tick();
    tick();
    set_ex(8'h00, 2'b00, 1'b0, 4'h0);
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("idle_quiet", O_NONE);

    // Load-use on rs1, then the bubble clears it.
    set_ex(8'h23, 2'b10, 1'b1, 4'h1);
    set_id(1'b1, 4'd3, 4'd7, 1'b1, 1'b1, 1'b0);
    chk("load_use_rs1", O_BUB);
    tick();
    set_ex(8'h00, 2'b00, 1'b0, 4'h0);
    chk("load_use_cleared", O_NONE);
    tick();
    set_ex(8'h43, 2'b10, 1'b1, 4'h1);
    set_id(1'b1, 4'd9, 4'd3, 1'b0, 1'b1, 1'b0);
    chk("load_use_rs2", O_BUB);

    // ALU RAW: forward or bubble depending on build.
    tick();
    set_ex(8'h05, 2'b00, 1'b1, 4'h2);
    set_id(1'b1, 4'd1, 4'd5, 1'b1, 1'b1, 1'b0);
    chk("alu_raw_rs2", O_FWD2);
    tick();
    set_id(1'b1, 4'd5, 4'd2, 1'b1, 1'b1, 1'b0);
    chk("alu_raw_rs1", O_FWD1);

    // r0 and unused / invalid operands never hazard.
    tick();
    set_ex(8'h10, 2'b10, 1'b1, 4'h1);
    set_id(1'b1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("r0_no_hazard", O_NONE);
    tick();
    set_ex(8'h05, 2'b10, 1'b1, 4'h1);
    set_id(1'b1, 4'd5, 4'd5, 1'b0, 1'b0, 1'b0);
    chk("unused_operand", O_NONE);
    tick();
    set_id(1'b0, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0);
    chk("id_invalid", O_NONE);
    tick();
    set_ex(8'h05, 2'b10, 1'b0, 4'h1);
    set_id(1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0);
    chk("no_reg_wr", O_NONE);

    // Multi-cycle op, MC_CYCLES=4: three stalled cycles then release.
    tick();
    set_ex(8'h05, 2'b00, 1'b0, 4'hF);
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("mc1_stall0", O_MC);
    tick();
    chk_state("mc1_busy_state", 2'd1);
    chk("mc1_stall1", O_MC);
    tick();
    set_ex(8'h05, 2'b00, 1'b1, 4'hF);
    set_id(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("mc1_stall2_haz_masked", O_MC);
    tick();
    chk("mc1_release_raw", O_FWD1);
    // Back-to-back op detected in IDLE right after release.
    tick();
    set_ex(8'h06, 2'b00, 1'b0, 4'hF);
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk_state("mc2_idle_state", 2'd0);
    chk("mc2_stall0", O_MC);
    tick();
    chk("mc2_stall1", O_MC);
    tick();
    chk("mc2_stall2", O_MC);
    tick();
    chk("mc2_release", O_NONE);
    tick();
    set_ex(8'h00, 2'b00, 1'b0, 4'h0);
    chk("mc_done", O_NONE);

    // HALT while stage A holds an ALU op.
    set_ex(8'h07, 2'b00, 1'b1, 4'h2);
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("halt_accept", O_BUB);
    tick();
    set_ex(8'h00, 2'b00, 1'b0, 4'h0);
    chk_state("drain_state", 2'd2);
    chk("halt_drain", O_BUB);
    tick();
    chk("halt_sys_plus2", O_HALT);
    for (int i = 0; i < 10; i++) begin
      tick();
      set_ex(8'h03, 2'b10, 1'b1, (i % 2 == 0) ? 4'hF : 4'h1);
      set_id(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 1'b0);
    end
    chk("halt_sticky", O_HALT);
    chk_state("halted_state", 2'd3);

    // Reset leaves HALTED; then reset mid-MC_BUSY after one stalled cycle.
    rst = 1'b1;
    set_ex(8'h00, 2'b00, 1'b0, 4'h0);
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("reset_from_halt", O_NONE);
    tick();
    rst = 1'b0;
    set_ex(8'h08, 2'b00, 1'b0, 4'hF);
    chk("mc3_stall0", O_MC);
    tick();
    rst = 1'b1;
    chk("reset_mid_mc", O_NONE);
    chk_state("reset_mid_mc_state", 2'd0);
    tick();
    rst = 1'b0;
    chk("mc4_stall0", O_MC);
    tick();
    chk("mc4_stall1", O_MC);
    tick();
    chk("mc4_stall2", O_MC);
    tick();
    chk("mc4_release", O_NONE);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
